arrayadd_ctrl: RTL

- Job controller that sequences the two-operand array-add datapath.
- Accepts a command (base index, length) and issues paired reads to operand memories A and B, which share one address.
- Adds the returned words and streams the sums out over a valid/ready interface with backpressure.
- Pulses done after the last sum is accepted. Sits between the host/command logic and the synchronous-read operand RAMs.

---
 rtl/arrayadd_pkg.sv | 15 +
 rtl/arrayadd_skid.sv | 39 +++
 rtl/arrayadd_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/arrayadd_pkg.sv
// Shared types and constants for the array-add job controller.
// The optional running-total output is enabled by ARRAYADD_TOTAL_EN.
package arrayadd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 32;
    localparam int SKID_DEPTH  = 2;
    localparam int CNT_W       = 2;
    localparam int TOTAL_W_DEF = DATA_W_DEF + ADDR_W_DEF + 2;

    function automatic int total_w(input int data_w, input int addr_w);
        return data_w + addr_w + 2;
    endfunction
endpackage

// File: rtl/arrayadd_skid.sv
// Two-entry in-order valid/ready buffer; exports its fill count so the
// controller can limit reads in flight to the free space.
module arrayadd_skid
    import arrayadd_pkg::*;
#(
    parameter int W = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0] entry [SKID_DEPTH];
    logic         pop;
    logic         wr_hi;

    assign pop       = out_valid & out_ready;
    assign out_valid = (count != '0);
    assign out_data  = entry[0];
    // Slot for an incoming word is computed after this cycle's pop shifts the queue.
    assign wr_hi     = ((count - CNT_W'(pop)) == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) entry[i] <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < SKID_DEPTH - 1; i++) entry[i] <= entry[i+1];
            end
            if (in_valid) entry[wr_hi] <= in_data;
            count <= count + CNT_W'(in_valid) - CNT_W'(pop);
        end
    end
endmodule

// File: rtl/arrayadd_ctrl.sv
// Job controller: reads paired operands from A/B memories, adds them and
// streams sums out. Define ARRAYADD_TOTAL_EN to add the out_total accumulator.
module arrayadd_ctrl
    import arrayadd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_a_rdata,
    input  logic [DATA_W-1:0] mem_b_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_carry,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef ARRAYADD_TOTAL_EN
    ,
    output logic [DATA_W+ADDR_W+1:0] out_total
`endif
);
    localparam int PW = DATA_W + 2;
    localparam logic [ADDR_W:0] LEN_ONE = 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx_q;
    logic              rd_vld_p1;
    logic              rd_last_p1;
    logic              accept;
    logic              pop;
    logic              last_rd;
    logic [CNT_W-1:0]  skid_count;
    logic [CNT_W:0]    occupancy;
    logic [DATA_W:0]   add_p1;
    logic [PW-1:0]     skid_out;

    assign accept   = cmd_valid & cmd_ready;
    assign pop      = out_valid & out_ready;
    assign last_rd  = (idx_q == len_q - LEN_ONE);
    assign mem_addr = base_q + idx_q[ADDR_W-1:0];
    // Words already buffered plus the one still returning from memory, net of this pop.
    assign occupancy = {1'b0, skid_count} + (CNT_W+1)'(rd_vld_p1) - (CNT_W+1)'(pop);

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        mem_rd_en = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = (cmd_len == '0) ? DONE : RUN;
            end
            RUN: begin
                mem_rd_en = (occupancy < (CNT_W+1)'(SKID_DEPTH));
                if (mem_rd_en && last_rd) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && out_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                base_q <= cmd_base;
                len_q  <= cmd_len;
                idx_q  <= '0;
            end else if (mem_rd_en) begin
                idx_q <= idx_q + LEN_ONE;
            end
            rd_vld_p1  <= mem_rd_en;
            rd_last_p1 <= mem_rd_en & last_rd;
        end
    end

    // p1: memory data valid; sum enters the skid buffer at the end of this cycle
    assign add_p1 = {1'b0, mem_a_rdata} + {1'b0, mem_b_rdata};

    arrayadd_skid #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_vld_p1),
        .in_data   ({add_p1, rd_last_p1}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out),
        .count     (skid_count)
    );

    assign out_carry = skid_out[PW-1];
    assign out_sum   = skid_out[PW-2:1];
    assign out_last  = skid_out[0];

`ifdef ARRAYADD_TOTAL_EN
    localparam int TOTAL_W = total_w(DATA_W, ADDR_W);
    logic [TOTAL_W-1:0] total_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      total_q <= '0;
        else if (accept) total_q <= '0;
        else if (pop)    total_q <= total_q + TOTAL_W'({out_carry, out_sum});
    end

    assign out_total = total_q;
`endif
endmodule
